// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU front end.
// Holds the datapath widths, the reset program counter, the fetch FSM state
// encoding and the entry format used by the prefetch FIFO.
package cpu_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer between the fetch FSM and decode.
// First-word-fall-through: the head entry is visible on data_o whenever
// valid_o is high. Flush wins over push and pop. The head reads as zero
// while the buffer is empty, so downstream sees clean zeros after a reset.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  data_i,
    input  logic          pop_i,
    output fetch_entry_t  data_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rdPtr_q;
    logic [PW-1:0] wrPtr_q;
    logic [CW-1:0] count_q;
    logic          doPush;
    logic          doPop;

    assign doPop  = pop_i && (count_q != '0);
    assign doPush = push_i && ((int'(count_q) < DEPTH) || doPop);

    // Storage array; entries need no reset because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (doPush && !flush_i) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    // Pointers and occupancy; flush empties the buffer in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + PW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            if (doPush && !doPop) begin
                count_q <= count_q + CW'(1);
            end else if (doPop && !doPush) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rdPtr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding read at a time
// to program memory, buffers responses in fetch_fifo and hands them to decode.
// A redirect from execute flushes the buffer and discards any in-flight read.
// Optional build macro FETCH_STALL_CNT_EN adds an 8-bit saturating count of
// cycles where fetch is enabled but decode has nothing to consume.
// Address/instruction widths and the reset PC come from cpu_pkg.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [7:0]         stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] issueAddr_q;
    logic              req_q;
    logic              drop_q;

    logic [CW-1:0]     fifoCount;
    fetch_entry_t      headEntry;
    fetch_entry_t      pushEntry;
    logic              headValid;
    logic              pushEn;
    logic              popEn;
    logic              roomNow;
    logic              roomAfter;
    logic [ADDR_W-1:0] pcEff;

    // A redirect overrides any pop or push happening in the same cycle.
    assign popEn     = headValid && instr_ready && !redirect_valid;
    assign pushEn    = (state_q == WAIT) && imem_rvalid && !drop_q && !redirect_valid;
    assign pushEntry = '{instr: imem_rdata, pc: issueAddr_q};
    assign pcEff     = redirect_valid ? redirect_pc : pc_q;

    // roomAfter looks at occupancy once this cycle's response lands, so the
    // next request is only issued if its response is guaranteed a slot.
    assign roomNow   = (int'(fifoCount) < DEPTH);
    assign roomAfter = ((int'(fifoCount) + 1 - int'(popEn)) < DEPTH);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush_i (redirect_valid),
        .push_i  (pushEn),
        .data_i  (pushEntry),
        .pop_i   (popEn),
        .data_o  (headEntry),
        .valid_o (headValid),
        .count_o (fifoCount)
    );

    // Fetch FSM: PC, request handshake and drop tracking for squashed reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            issueAddr_q <= RESET_PC;
            req_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pc_q <= pcEff;
                    if (enable && (redirect_valid || roomNow)) begin
                        state_q     <= REQ;
                        req_q       <= 1'b1;
                        issueAddr_q <= pcEff;
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        state_q <= WAIT;
                        req_q   <= 1'b0;
                        drop_q  <= redirect_valid;
                        pc_q    <= redirect_valid ? redirect_pc : pc_q + ADDR_W'(1);
                    end else if (redirect_valid) begin
                        pc_q        <= redirect_pc;
                        issueAddr_q <= redirect_pc;
                        req_q       <= enable;
                        state_q     <= enable ? REQ : IDLE;
                    end
                end
                WAIT: begin
                    pc_q <= pcEff;
                    if (imem_rvalid) begin
                        drop_q <= 1'b0;
                        if (enable && (redirect_valid || roomAfter)) begin
                            state_q     <= REQ;
                            req_q       <= 1'b1;
                            issueAddr_q <= pcEff;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (redirect_valid) begin
                        drop_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    drop_q  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = issueAddr_q;
    assign instr_valid = headValid;
    assign instr       = headEntry.instr;
    assign instr_pc    = headEntry.pc;

`ifdef FETCH_STALL_CNT_EN
    logic [7:0] stallCnt_q;

    // Count starved cycles, sticking at the maximum instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCnt_q <= '0;
        end else if (enable && !headValid && (stallCnt_q != 8'hFF)) begin
            stallCnt_q <= stallCnt_q + 8'd1;
        end
    end

    assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small program-memory model that answers
// a granted read with data 0x1000 + address after a programmable latency.
// Build with FETCH_STALL_CNT_EN defined to also exercise the stall counter.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  instr_pc;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
`ifdef FETCH_STALL_CNT_EN
    logic [7:0]  stall_cnt;
`endif

    int          assertCount = 0;
    int          failCount   = 0;

    int          memLat;
    bit          memGrant;
    int          pendCnt;
    logic [15:0] pendData;

    fetch_unit #(
        .DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck design still produces a report.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to the next falling edge and update the memory model there.
    task automatic applyStimulus();
        @(negedge clk);
        imem_rvalid = 1'b0;
        if (pendCnt > 0) begin
            pendCnt--;
            if (pendCnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pendData;
            end
        end
        if (imem_req && memGrant && pendCnt == 0) begin
            imem_gnt = 1'b1;
            pendCnt  = memLat;
            pendData = 16'h1000 + {8'h00, imem_addr};
        end else begin
            imem_gnt = 1'b0;
        end
    endtask

    // Step until the head is valid, reporting how many cycles it took.
    task automatic waitValid(input int budget, output int cycles);
        cycles = 0;
        do begin
            applyStimulus();
            cycles++;
        end while (!instr_valid && cycles < budget);
        if (!instr_valid) begin
            checkOutput("valid timeout", 32'(instr_valid), 32'd1);
            cycles = -1;
        end
    endtask

    // Hold reset for two cycles with a quiet bus, release on a falling edge.
    task automatic doReset();
        reset          = 1'b0;
        enable         = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        memGrant       = 1'b1;
        memLat         = 1;
        pendCnt        = 0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 16'h0000;
        repeat (2) applyStimulus();
        reset = 1'b1;
    endtask

    // Directed scenarios, each starting from a fresh reset.
    initial begin
        int cyc;

        reset = 1'b0;
        doReset();
        checkOutput("rst imem_req", 32'(imem_req), 32'd0);
        checkOutput("rst imem_addr", 32'(imem_addr), 32'h00);
        checkOutput("rst instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst instr", 32'(instr), 32'h0000);
        checkOutput("rst instr_pc", 32'(instr_pc), 32'h00);
`ifdef FETCH_STALL_CNT_EN
        checkOutput("rst stall_cnt", 32'(stall_cnt), 32'd0);
`endif

        $display("[TB] streaming fetch with decode always ready");
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            waitValid(20, cyc);
            checkOutput("stream instr", 32'(instr), 32'h1000 + 32'(k));
            checkOutput("stream pc", 32'(instr_pc), 32'(k));
            if (k > 0) begin
                checkOutput("stream gap", 32'(cyc), 32'd2);
            end
        end

        $display("[TB] decode stalled, buffer fills");
        doReset();
        instr_ready = 1'b0;
        enable      = 1'b1;
        repeat (10) applyStimulus();
        for (int k = 0; k < 3; k++) begin
            checkOutput("full req", 32'(imem_req), 32'd0);
            checkOutput("full valid", 32'(instr_valid), 32'd1);
            checkOutput("full head instr", 32'(instr), 32'h1000);
            checkOutput("full head pc", 32'(instr_pc), 32'h00);
            applyStimulus();
        end
        instr_ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            waitValid(20, cyc);
            checkOutput("drain instr", 32'(instr), 32'h1000 + 32'(k));
            checkOutput("drain pc", 32'(instr_pc), 32'(k));
        end

        $display("[TB] redirect while a read is outstanding");
        doReset();
        memLat = 3;
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            waitValid(40, cyc);
            checkOutput("pre-redirect pc", 32'(instr_pc), 32'(k));
        end
        instr_ready = 1'b0;
        applyStimulus();
        checkOutput("pre-redirect held pc", 32'(instr_pc), 32'h04);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        applyStimulus();
        redirect_valid = 1'b0;
        checkOutput("flush valid", 32'(instr_valid), 32'd0);
        instr_ready = 1'b1;
        waitValid(40, cyc);
        checkOutput("redirect instr", 32'(instr), 32'h1040);
        checkOutput("redirect pc", 32'(instr_pc), 32'h40);
        waitValid(40, cyc);
        checkOutput("redirect next pc", 32'(instr_pc), 32'h41);

        $display("[TB] program counter wrap");
        doReset();
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFE;
        applyStimulus();
        redirect_valid = 1'b0;
        enable         = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] expPc;
            expPc = 8'hFE + 8'(k);
            waitValid(20, cyc);
            checkOutput("wrap pc", 32'(instr_pc), 32'(expPc));
            checkOutput("wrap instr", 32'(instr), 32'h1000 + 32'(expPc));
        end

        $display("[TB] asynchronous reset with a read outstanding");
        doReset();
        memLat      = 3;
        instr_ready = 1'b0;
        enable      = 1'b1;
        waitValid(40, cyc);
        checkOutput("pre-reset pc", 32'(instr_pc), 32'h00);
        applyStimulus();
        #2;
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        checkOutput("async rst valid", 32'(instr_valid), 32'd0);
        checkOutput("async rst req", 32'(imem_req), 32'd0);
        checkOutput("async rst instr", 32'(instr), 32'h0000);
        checkOutput("async rst addr", 32'(imem_addr), 32'h00);
        applyStimulus();
        reset = 1'b1;
        applyStimulus();
        checkOutput("late rvalid present", 32'(imem_rvalid), 32'd1);
        applyStimulus();
        checkOutput("late rvalid ignored", 32'(instr_valid), 32'd0);
        instr_ready = 1'b1;
        enable      = 1'b1;
        waitValid(40, cyc);
        checkOutput("post-reset pc", 32'(instr_pc), 32'h00);
        checkOutput("post-reset instr", 32'(instr), 32'h1000);

        $display("[TB] memory never grants");
        doReset();
        memGrant = 1'b0;
        enable   = 1'b1;
        repeat (100) applyStimulus();
`ifdef FETCH_STALL_CNT_EN
        checkOutput("stall_cnt 100", 32'(stall_cnt), 32'd100);
`endif
        repeat (200) applyStimulus();
        checkOutput("held req", 32'(imem_req), 32'd1);
        checkOutput("held addr", 32'(imem_addr), 32'h00);
        checkOutput("starved valid", 32'(instr_valid), 32'd0);
`ifdef FETCH_STALL_CNT_EN
        checkOutput("stall_cnt sat", 32'(stall_cnt), 32'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
